// File: rtl/connect4_pkg.sv
// Connect4 shared definitions: cell and status codes,
// run-check directions and default board geometry.
package connect4_pkg;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;
  localparam int DEF_WIN_LEN = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1 = 2'b01;
  localparam logic [1:0] CELL_P2 = 2'b10;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_WIN = 2'b01;
  localparam logic [1:0] ST_TIE = 2'b10;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_e;

endpackage

// File: rtl/connect4_run_counter.sv
// Combinational same-colour run length through one cell
// along one direction, saturated at WIN_LEN.
module connect4_run_counter
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic [ROWS-1:0][COLS-1:0][1:0] board,
  input  logic [2:0]                     row,
  input  logic [2:0]                     col,
  input  dir_e                           dir,
  input  logic [1:0]                     colour,
  output logic [2:0]                     run
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [2:0] WIN = 3'(WIN_LEN);

  function automatic logic [2:0] side(
    input logic [ROWS-1:0][COLS-1:0][1:0] b,
    input logic [2:0] r0,
    input logic [2:0] c0,
    input logic [1:0] clr,
    input int dr,
    input int dc
  );
    logic [2:0] n;
    logic go;
    int r;
    int c;
    n = '0;
    go = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      r = int'(r0) + dr * k;
      c = int'(c0) + dc * k;
      // Off-board cells end the run like a foreign colour
      if (go && r >= 0 && r < ROWS && c >= 0 && c < COLS)
        go = (b[r[RW-1:0]][c[CW-1:0]] == clr);
      else
        go = 1'b0;
      if (go) n = n + 3'd1;
    end
    return n;
  endfunction

  int dr;
  int dc;
  logic [2:0] fwd;
  logic [2:0] bwd;
  logic [2:0] total;

  always_comb begin
    dr = 0;
    dc = 1;
    unique case (dir)
      DIR_H: begin dr = 0; dc = 1; end
      DIR_V: begin dr = 1; dc = 0; end
      DIR_D: begin dr = 1; dc = 1; end
      DIR_A: begin dr = -1; dc = 1; end
    endcase
    fwd = side(board, row, col, colour, dr, dc);
    bwd = side(board, row, col, colour, -dr, -dc);
    total = 3'd1 + fwd + bwd;
    run = (total >= WIN) ? WIN : total;
  end

endmodule

// File: rtl/connect4_board_engine.sv
// Connect4 move engine: holds the board, places drops,
// checks four directions and reports win/tie/turn.
module connect4_board_engine
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_done,
  output logic       invalid_move,
  output logic       player_turn,
  output logic [1:0] in_game_status,
  output logic       winner,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLACE   = 3'd1;
  localparam logic [2:0] S_CHK_H   = 3'd2;
  localparam logic [2:0] S_CHK_V   = 3'd3;
  localparam logic [2:0] S_CHK_D   = 3'd4;
  localparam logic [2:0] S_CHK_A   = 3'd5;
  localparam logic [2:0] S_RESOLVE = 3'd6;
  localparam logic [2:0] S_OVER    = 3'd7;

  localparam logic [2:0] ROWS3 = 3'(ROWS);
  localparam logic [2:0] COLS3 = 3'(COLS);
  localparam logic [2:0] WIN3  = 3'(WIN_LEN);
  localparam logic [5:0] CELLS = 6'(ROWS * COLS);

  logic [2:0]                     state;
  logic [ROWS-1:0][COLS-1:0][1:0] board;
  logic [COLS-1:0][2:0]           height;
  logic [5:0]                     moves;
  logic [2:0]                     col_q;
  logic [2:0]                     row_q;
  logic                           hit;
  logic                           col_bad;
  logic [1:0]                     colour;
  dir_e                           dir;
  logic [2:0]                     run;

  assign move_ready = (state == S_IDLE);
  assign colour = player_turn ? CELL_P2 : CELL_P1;
  assign col_bad = (col_q >= COLS3) || (height[col_q] == ROWS3);
  assign rd_cell = (rd_row < ROWS3 && rd_col < COLS3) ?
                   board[rd_row][rd_col] : CELL_EMPTY;

  always_comb begin
    dir = DIR_H;
    unique case (1'b1)
      (state == S_CHK_V): dir = DIR_V;
      (state == S_CHK_D): dir = DIR_D;
      (state == S_CHK_A): dir = DIR_A;
      default:            dir = DIR_H;
    endcase
  end

  connect4_run_counter #(
    .ROWS(ROWS),
    .COLS(COLS),
    .WIN_LEN(WIN_LEN)
  ) u_run (
    .board(board),
    .row(row_q),
    .col(col_q),
    .dir(dir),
    .colour(colour),
    .run(run)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      board          <= '0;
      height         <= '0;
      moves          <= '0;
      col_q          <= '0;
      row_q          <= '0;
      hit            <= 1'b0;
      player_turn    <= 1'b0;
      in_game_status <= ST_PLAYING;
      winner         <= 1'b0;
      invalid_move   <= 1'b0;
      move_done      <= 1'b0;
    end else begin
      invalid_move <= 1'b0;
      move_done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (move_valid) begin
            col_q <= move_col;
            state <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (col_bad) begin
            invalid_move <= 1'b1;
            state        <= S_IDLE;
          end else begin
            board[height[col_q]][col_q] <= colour;
            height[col_q] <= height[col_q] + 3'd1;
            moves         <= moves + 6'd1;
            row_q         <= height[col_q];
            hit           <= 1'b0;
            state         <= S_CHK_H;
          end
        end
        S_CHK_H, S_CHK_V, S_CHK_D, S_CHK_A: begin
          hit   <= hit | (run >= WIN3);
          state <= state + 3'd1;
        end
        S_RESOLVE: begin
          // A win on the last free cell outranks the tie
          if (hit) begin
            in_game_status <= ST_WIN;
            winner         <= player_turn;
            state          <= S_OVER;
          end else if (moves == CELLS) begin
            in_game_status <= ST_TIE;
            state          <= S_OVER;
          end else begin
            player_turn <= ~player_turn;
            move_done   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_OVER: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_board_engine.sv
// Directed bench for connect4_board_engine: latency,
// invalid moves, wins in several directions, tie, reset.
module tb_connect4_board_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic       move_ready;
  logic       move_done;
  logic       invalid_move;
  logic       player_turn;
  logic [1:0] in_game_status;
  logic       winner;
  logic [2:0] rd_row = 3'd0;
  logic [2:0] rd_col = 3'd0;
  logic [1:0] rd_cell;

  int passed = 0;
  int total = 0;

  connect4_board_engine dut (
    .clk(clk),
    .reset(reset),
    .move_valid(move_valid),
    .move_col(move_col),
    .move_ready(move_ready),
    .move_done(move_done),
    .invalid_move(invalid_move),
    .player_turn(player_turn),
    .in_game_status(in_game_status),
    .winner(winner),
    .rd_row(rd_row),
    .rd_col(rd_col),
    .rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0;
    move_valid = 1'b0;
    move_col = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 done, 1 invalid, 2 game over, 3 timeout
  task automatic do_move(input int col, output int lat, output int kind);
    int n;
    @(posedge clk);
    #1;
    n = 0;
    while (!move_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    move_valid = 1'b1;
    move_col = 3'(col);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    lat = 0;
    kind = 3;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (invalid_move) begin lat = i; kind = 1; break; end
      if (move_done) begin lat = i; kind = 0; break; end
      if (in_game_status != 2'b00) begin lat = i; kind = 2; break; end
    end
  endtask

  task automatic play(input int cols[$], output int dones,
                      output int kind, output int lat);
    dones = 0;
    kind = 3;
    lat = 0;
    foreach (cols[i]) begin
      do_move(cols[i], lat, kind);
      if (kind == 0) dones++;
    end
  endtask

  task automatic peek(input int r, input int c, output logic [1:0] v);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1 v = rd_cell;
  endtask

  task automatic test_reset();
    logic [1:0] v;
    reset = 1'b0;
    #3;
    peek(0, 0, v);
    total++;
    if ({move_ready, move_done, invalid_move, player_turn, winner} !== 5'b10000)
      $display("FAIL rst_flags got %b want 10000",
               {move_ready, move_done, invalid_move, player_turn, winner});
    else passed++;
    total++;
    if (in_game_status !== 2'b00 || v !== 2'b00)
      $display("FAIL rst_status got %b/%b want 00/00", in_game_status, v);
    else passed++;
    apply_reset();
  endtask

  task automatic test_first_drop();
    int lat, kind;
    logic [1:0] v;
    apply_reset();
    do_move(3, lat, kind);
    total++;
    if (kind !== 0 || lat !== 6)
      $display("FAIL t1_done got kind %0d lat %0d want 0 6", kind, lat);
    else passed++;
    peek(0, 3, v);
    total++;
    if (v !== 2'b01) $display("FAIL t1_cell got %b want 01", v);
    else passed++;
    total++;
    if (player_turn !== 1'b1 || in_game_status !== 2'b00 || move_ready !== 1'b1)
      $display("FAIL t1_state got %b %b %b want 1 00 1",
               player_turn, in_game_status, move_ready);
    else passed++;
  endtask

  task automatic test_invalid();
    int q[$];
    int dones, kind, lat;
    logic [1:0] v, w;
    apply_reset();
    q = '{0, 0, 0, 0, 0, 0};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 6) $display("FAIL t2_fill got %0d want 6", dones);
    else passed++;
    do_move(0, lat, kind);
    total++;
    if (kind !== 1 || lat !== 1)
      $display("FAIL t2_full got kind %0d lat %0d want 1 1", kind, lat);
    else passed++;
    peek(5, 0, v);
    peek(4, 0, w);
    total++;
    if (v !== 2'b10 || w !== 2'b01 || player_turn !== 1'b0)
      $display("FAIL t2_board got %b %b turn %b want 10 01 0", v, w, player_turn);
    else passed++;
    do_move(7, lat, kind);
    total++;
    if (kind !== 1 || lat !== 1)
      $display("FAIL t2_range got kind %0d lat %0d want 1 1", kind, lat);
    else passed++;
    peek(6, 0, v);
    peek(0, 7, w);
    total++;
    if (v !== 2'b00 || w !== 2'b00)
      $display("FAIL t2_rd_oob got %b %b want 00 00", v, w);
    else passed++;
    do_move(1, lat, kind);
    peek(0, 1, v);
    total++;
    if (kind !== 0 || v !== 2'b01)
      $display("FAIL t2_after got kind %0d cell %b want 0 01", kind, v);
    else passed++;
  endtask

  task automatic test_horizontal_win();
    int q[$];
    int dones, kind, lat;
    logic [1:0] v;
    apply_reset();
    q = '{0, 0, 1, 1, 2, 2, 3};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 6 || kind !== 2 || lat !== 6)
      $display("FAIL t3_seq got %0d %0d %0d want 6 2 6", dones, kind, lat);
    else passed++;
    total++;
    if (in_game_status !== 2'b01 || winner !== 1'b0 || move_ready !== 1'b0)
      $display("FAIL t3_win got %b %b %b want 01 0 0",
               in_game_status, winner, move_ready);
    else passed++;
    move_valid = 1'b1;
    move_col = 3'd4;
    repeat (10) @(posedge clk);
    #1 move_valid = 1'b0;
    peek(0, 4, v);
    total++;
    if (v !== 2'b00 || in_game_status !== 2'b01 || player_turn !== 1'b0)
      $display("FAIL t3_over got %b %b %b want 00 01 0",
               v, in_game_status, player_turn);
    else passed++;
  endtask

  task automatic test_p2_wins();
    int q[$];
    int dones, kind, lat;
    apply_reset();
    q = '{2, 1, 3, 2, 3, 3, 4, 4, 4, 4};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 9 || kind !== 2)
      $display("FAIL t4_diag_seq got %0d %0d want 9 2", dones, kind);
    else passed++;
    total++;
    if (in_game_status !== 2'b01 || winner !== 1'b1 || player_turn !== 1'b1)
      $display("FAIL t4_diag got %b %b %b want 01 1 1",
               in_game_status, winner, player_turn);
    else passed++;
    apply_reset();
    q = '{0, 6, 0, 6, 0, 6, 1, 6};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 7 || kind !== 2 || in_game_status !== 2'b01 || winner !== 1'b1)
      $display("FAIL t4_vert got %0d %0d %b %b want 7 2 01 1",
               dones, kind, in_game_status, winner);
    else passed++;
  endtask

  task automatic test_tie();
    int q[$];
    int dones, kind, lat;
    logic [1:0] v, w;
    apply_reset();
    q = '{0, 2, 2, 0, 0, 2, 2, 0, 0, 2, 2, 0,
          1, 3, 3, 1, 1, 3, 3, 1, 1, 3, 3, 1,
          4, 6, 6, 4, 4, 6, 6, 4, 4, 6, 6, 4,
          5, 5, 5, 5, 5, 5};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 41 || kind !== 2 || lat !== 6)
      $display("FAIL t5_tie_seq got %0d %0d %0d want 41 2 6", dones, kind, lat);
    else passed++;
    total++;
    if (in_game_status !== 2'b10 || player_turn !== 1'b1 || move_ready !== 1'b0)
      $display("FAIL t5_tie got %b %b %b want 10 1 0",
               in_game_status, player_turn, move_ready);
    else passed++;
    peek(5, 5, v);
    peek(5, 6, w);
    total++;
    if (v !== 2'b10 || w !== 2'b01)
      $display("FAIL t5_top got %b %b want 10 01", v, w);
    else passed++;
    apply_reset();
    q = '{0, 3, 3, 0, 0, 3, 3, 0, 0, 3, 0, 3,
          1, 6, 6, 1, 1, 6, 6, 1, 1, 6, 1, 6,
          4, 2, 2, 4, 4, 2, 2, 4, 4, 2, 2, 4,
          5, 5, 5, 5, 5, 5};
    play(q, dones, kind, lat);
    total++;
    if (dones !== 41 || in_game_status !== 2'b01 || winner !== 1'b1)
      $display("FAIL t5_lastwin got %0d %b %b want 41 01 1",
               dones, in_game_status, winner);
    else passed++;
  endtask

  task automatic test_reset_mid_check();
    int q[$];
    int dones, kind, lat, bad;
    logic [1:0] v;
    apply_reset();
    q = '{1, 1, 1};
    play(q, dones, kind, lat);
    @(posedge clk);
    #1;
    move_valid = 1'b1;
    move_col = 3'd2;
    @(posedge clk);
    #1 move_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({move_ready, move_done, invalid_move, player_turn, winner} !== 5'b10000 ||
        in_game_status !== 2'b00)
      $display("FAIL t6_outs got %b %b want 10000 00",
               {move_ready, move_done, invalid_move, player_turn, winner},
               in_game_status);
    else passed++;
    bad = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        peek(r, c, v);
        if (v !== 2'b00) bad++;
      end
    total++;
    if (bad !== 0) $display("FAIL t6_clear got %0d nonempty want 0", bad);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b1;
    do_move(5, lat, kind);
    peek(0, 5, v);
    total++;
    if (kind !== 0 || lat !== 6 || v !== 2'b01 || player_turn !== 1'b1)
      $display("FAIL t6_next got %0d %0d %b %b want 0 6 01 1",
               kind, lat, v, player_turn);
    else passed++;
    peek(0, 1, v);
    total++;
    if (v !== 2'b00) $display("FAIL t6_old got %b want 00", v);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_drop();
    test_invalid();
    test_horizontal_win();
    test_p2_wins();
    test_tie();
    test_reset_mid_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
